mem_port_arbiter: RTL and testbench

//  Lets the pipelined core's instruction-fetch and data-memory stages share one memory port.

---
 rtl/mips_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory-port arbiter: bus width defaults and
// the arbiter state encoding.
package mips_pkg;

   localparam int MIPS_AW = 32;
   localparam int MIPS_DW = 32;

   typedef logic [1:0] arb_state_t;

   // Arbiter states
   localparam arb_state_t IDLE    = 2'd0;
   localparam arb_state_t GRANT_I = 2'd1;
   localparam arb_state_t GRANT_D = 2'd2;
   localparam arb_state_t RESP    = 2'd3;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting for a memory acknowledge. Cleared on every
// grant; saturates at TIMEOUT-1, where expired is raised.
module mem_timeout_ctr
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = (cnt_q == LAST);

   // Next count: clear wins, otherwise step while enabled and not yet at the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the MEM stage (D).
// Data requests win over fetch because the MEM-stage instruction is older.
// Every Mem* and Ready output comes straight from a flop, so there is no
// combinational path from the request inputs to the memory side.
//
// Handshake: a requester raises xReq and holds it (with address/data) until it
// sees xReady; address/data are captured only on the grant edge. MemReq stays
// high until the cycle MemAck is seen or the timeout expires; MemRData is
// taken only in the MemAck cycle. xReady is a one-cycle pulse, with Err
// alongside it if the access was abandoned on timeout.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int AW      = MIPS_AW,
   parameter int DW      = MIPS_DW,
   parameter int TIMEOUT = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          IReq,
   input  logic [AW-1:0] IAddr,
   output logic [DW-1:0] IRData,
   output logic          IReady,
   input  logic          DReq,
   input  logic          DWE,
   input  logic [AW-1:0] DAddr,
   input  logic [DW-1:0] DWData,
   output logic [DW-1:0] DRData,
   output logic          DReady,
   output logic          MemReq,
   output logic          MemWE,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   input  logic [DW-1:0] MemRData,
   input  logic          MemAck,
   output logic          Err
);

   arb_state_t    state_q,     state_d;
   logic          mem_req_q,   mem_req_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q,   i_rdata_d;
   logic [DW-1:0] d_rdata_q,   d_rdata_d;
   logic          i_ready_q,   i_ready_d;
   logic          d_ready_q,   d_ready_d;
   logic          err_q,       err_d;

   logic ctr_clear;
   logic ctr_en;
   logic ctr_expired;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk     (Clk),
      .reset   (Reset),
      .clear   (ctr_clear),
      .enable  (ctr_en),
      .expired (ctr_expired)
   );

   // Arbitration and transaction sequencing; Ready/Err default low so they pulse
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      err_d       = 1'b0;
      ctr_clear   = 1'b0;
      ctr_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (DReq) begin
               state_d     = GRANT_D;
               mem_req_d   = 1'b1;
               mem_we_d    = DWE;
               mem_addr_d  = DAddr;
               mem_wdata_d = DWData;
               ctr_clear   = 1'b1;
            end else if (IReq) begin
               state_d     = GRANT_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = IAddr;
               mem_wdata_d = '0;
               ctr_clear   = 1'b1;
            end
         end
         GRANT_I, GRANT_D: begin
            if (MemAck || ctr_expired) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (state_q == GRANT_D) begin
                  d_ready_d = 1'b1;
               end else begin
                  i_ready_d = 1'b1;
               end
            end else begin
               ctr_en = 1'b1;
            end
            // An ack in the last counter cycle still counts as a completion
            if (MemAck) begin
               if (state_q == GRANT_I) begin
                  i_rdata_d = MemRData;
               end else if (!mem_we_q) begin
                  d_rdata_d = MemRData;
               end
            end else if (ctr_expired) begin
               err_d = 1'b1;
               if (state_q == GRANT_I) begin
                  i_rdata_d = '0;
               end else begin
                  d_rdata_d = '0;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         err_q       <= err_d;
      end
   end

   assign MemReq   = mem_req_q;
   assign MemWE    = mem_we_q;
   assign MemAddr  = mem_addr_q;
   assign MemWData = mem_wdata_q;
   assign IRData   = i_rdata_q;
   assign DRData   = d_rdata_q;
   assign IReady   = i_ready_q;
   assign DReady   = d_ready_q;
   assign Err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the bench plays both requesters and the memory.
// Each episode is described at transaction level (who asks, what, and how many
// cycles the memory waits before acking); the expected cycle-by-cycle outputs
// are derived from grant/ready times computed with plain arithmetic.
module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          IReq;
   logic [AW-1:0] IAddr;
   logic [DW-1:0] IRData;
   logic          IReady;
   logic          DReq;
   logic          DWE;
   logic [AW-1:0] DAddr;
   logic [DW-1:0] DWData;
   logic [DW-1:0] DRData;
   logic          DReady;
   logic          MemReq;
   logic          MemWE;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWData;
   logic [DW-1:0] MemRData;
   logic          MemAck;
   logic          Err;

   mem_port_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .IReq     (IReq),
      .IAddr    (IAddr),
      .IRData   (IRData),
      .IReady   (IReady),
      .DReq     (DReq),
      .DWE      (DWE),
      .DAddr    (DAddr),
      .DWData   (DWData),
      .DRData   (DRData),
      .DReady   (DReady),
      .MemReq   (MemReq),
      .MemWE    (MemWE),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemRData (MemRData),
      .MemAck   (MemAck),
      .Err      (Err)
   );

   // Clock
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errors = 0;

   // Memory contents, word-indexed by address bits [7:2]
   logic [DW-1:0] mem_model [0:63];
   // Load data returned by the memory, waiting to be reported by a Ready pulse
   logic [DW-1:0] exp_q [$];
   logic [AW-1:0] exp_mem_addr;
   logic [DW-1:0] exp_i_rdata;
   logic [DW-1:0] exp_d_rdata;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string ph, input logic e_req, input logic e_ir,
                                input logic e_dr, input logic e_err, input logic chk_we,
                                input logic e_we, input logic chk_wd, input logic [DW-1:0] e_wd);
      check_eq({ph, ".MemReq"}, MemReq, e_req);
      check_eq({ph, ".IReady"}, IReady, e_ir);
      check_eq({ph, ".DReady"}, DReady, e_dr);
      check_eq({ph, ".Err"}, Err, e_err);
      check_eq({ph, ".MemAddr"}, MemAddr, exp_mem_addr);
      check_eq({ph, ".IRData"}, IRData, exp_i_rdata);
      check_eq({ph, ".DRData"}, DRData, exp_d_rdata);
      if (chk_we) check_eq({ph, ".MemWE"}, MemWE, e_we);
      if (chk_wd) check_eq({ph, ".MemWData"}, MemWData, e_wd);
   endtask

   // No requests; the memory may throw stray acks, which must be ignored
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         IReq     = 1'b0;
         DReq     = 1'b0;
         MemAck   = ($urandom_range(0, 3) == 0);
         MemRData = $urandom;
         @(posedge Clk); #1;
         check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end
      MemAck = 1'b0;
   endtask

   // One episode starting with the DUT idle: D and/or I request in cycle 0.
   // A delay >= TIMEOUT means the memory never acks that access.
   task automatic run_episode(input bit has_i, input bit has_d, input logic [AW-1:0] i_addr,
                              input logic [AW-1:0] d_addr, input logic d_we,
                              input logic [DW-1:0] d_wdata, input int i_dly, input int d_dly);
      int            g [2];
      int            r [2];
      int            dly [2];
      bit            is_d [2];
      bit            to [2];
      logic [AW-1:0] addr [2];
      logic          we [2];
      logic [DW-1:0] wd [2];
      logic [DW-1:0] v;
      int            n;
      int            kd;
      int            ki;
      logic          e_req, e_ir, e_dr, e_err, chk_we, e_we, chk_wd;
      logic [DW-1:0] e_wd;
      bit            in_window;
      n = 0;
      if (has_d) begin
         is_d[n] = 1'b1; addr[n] = d_addr; we[n] = d_we; wd[n] = d_wdata; dly[n] = d_dly; n++;
      end
      if (has_i) begin
         is_d[n] = 1'b0; addr[n] = i_addr; we[n] = 1'b0; wd[n] = '0; dly[n] = i_dly; n++;
      end
      kd = 0;
      ki = has_d ? 1 : 0;
      // D wins when both are pending; the loser is granted the cycle after RESP
      for (int k = 0; k < n; k++) begin
         g[k]  = (k == 0) ? 0 : r[k-1] + 1;
         to[k] = (dly[k] >= TIMEOUT);
         r[k]  = g[k] + 2 + (to[k] ? TIMEOUT - 1 : dly[k]);
      end
      IReq     = has_i;
      IAddr    = i_addr;
      DReq     = has_d;
      DWE      = d_we;
      DAddr    = d_addr;
      DWData   = d_wdata;
      MemAck   = ($urandom_range(0, 3) == 0);
      MemRData = $urandom;
      for (int c = 1; c <= r[n-1] + 1; c++) begin
         @(posedge Clk); #1;
         e_req = 0; e_ir = 0; e_dr = 0; e_err = 0; chk_we = 0; e_we = 0; chk_wd = 0; e_wd = '0;
         for (int k = 0; k < n; k++) begin
            if (c == g[k] + 1) exp_mem_addr = addr[k];
            if (c > g[k] && c < r[k]) begin
               e_req = 1'b1; chk_we = 1'b1; e_we = we[k]; chk_wd = we[k]; e_wd = wd[k];
            end
            if (c == r[k]) begin
               if (is_d[k]) e_dr = 1'b1; else e_ir = 1'b1;
               e_err = to[k];
               if (to[k]) v = '0;
               else if (we[k]) v = exp_d_rdata;
               else v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
               if (is_d[k]) exp_d_rdata = v; else exp_i_rdata = v;
            end
         end
         check_outputs("txn", e_req, e_ir, e_dr, e_err, chk_we, e_we, chk_wd, e_wd);
         if (c == r[n-1] + 1) begin
            MemAck = 1'b0;
            break;
         end
         // Memory side
         MemAck    = 1'b0;
         MemRData  = $urandom;
         in_window = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (c > g[k] && c < r[k]) in_window = 1'b1;
            if (!to[k] && c == g[k] + 1 + dly[k]) begin
               MemAck   = 1'b1;
               MemRData = mem_model[addr[k][7:2]];
               if (we[k]) mem_model[addr[k][7:2]] = wd[k];
               else exp_q.push_back(mem_model[addr[k][7:2]]);
            end
         end
         if (!in_window && $urandom_range(0, 3) == 0) MemAck = 1'b1;
         // Requesters: hold until granted, then may wander or drop; quiet from Ready on
         if (has_d) begin
            if (c >= r[kd]) DReq = 1'b0;
            else if (c > g[kd]) begin
               DReq   = 1'($urandom_range(0, 1));
               DWE    = 1'($urandom_range(0, 1));
               DAddr  = $urandom;
               DWData = $urandom;
            end
         end
         if (has_i) begin
            if (c >= r[ki]) IReq = 1'b0;
            else if (c > g[ki]) begin
               IReq  = 1'($urandom_range(0, 1));
               IAddr = $urandom;
            end
         end
      end
   endtask

   // Reset while a data load is waiting for its ack
   task automatic reset_mid_grant();
      DReq   = 1'b1;
      DWE    = 1'b0;
      DAddr  = 32'h60;
      DWData = $urandom;
      IReq   = 1'b0;
      MemAck = 1'b0;
      @(posedge Clk); #1;
      exp_mem_addr = 32'h60;
      check_eq("rst_mid.pre_MemReq", MemReq, 1'b1);
      check_eq("rst_mid.pre_MemAddr", MemAddr, exp_mem_addr);
      Reset = 1'b1;
      DReq  = 1'b0;
      @(posedge Clk); #1;
      Reset        = 1'b0;
      exp_mem_addr = '0;
      exp_i_rdata  = '0;
      exp_d_rdata  = '0;
      check_outputs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
      idle_cycles(3);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      return a;
   endfunction

   function automatic int rand_dly();
      int sel;
      sel = $urandom_range(0, 11);
      if (sel == 0) return TIMEOUT + 3;
      if (sel == 1) return TIMEOUT - 1;
      return $urandom_range(0, 4);
   endfunction

   initial begin
      int kind;
      Reset    = 1'b1;
      IReq     = 1'b0;
      IAddr    = '0;
      DReq     = 1'b0;
      DWE      = 1'b0;
      DAddr    = '0;
      DWData   = '0;
      MemRData = '0;
      MemAck   = 1'b0;
      for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
      exp_mem_addr = '0;
      exp_i_rdata  = '0;
      exp_d_rdata  = '0;
      repeat (2) @(posedge Clk);
      #1;
      check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
      Reset = 1'b0;

      // Single fetch, ack in the first MemReq cycle
      mem_model[16] = 32'h2002_0005;
      run_episode(1'b1, 1'b0, 32'h40, '0, 1'b0, '0, 0, 0);
      idle_cycles(1);
      // Simultaneous requests: store first, then fetch
      run_episode(1'b1, 1'b1, 32'h44, 32'h54, 1'b1, 32'd7, 0, 0);
      // Load with a slow memory
      mem_model[24] = 32'h0000_DEAD;
      run_episode(1'b0, 1'b1, '0, 32'h60, 1'b0, '0, 0, 5);
      // Load that never gets acked
      run_episode(1'b0, 1'b1, '0, 32'h68, 1'b0, '0, 0, TIMEOUT + 4);
      // Ack arriving in the very last cycle before the timeout fires
      run_episode(1'b1, 1'b0, 32'h70, '0, 1'b0, '0, TIMEOUT - 1, 0);
      // Store that times out
      run_episode(1'b0, 1'b1, '0, 32'h74, 1'b1, 32'h1234_5678, 0, TIMEOUT);
      idle_cycles(2);
      // Reset mid-transaction, then a fresh fetch
      reset_mid_grant();
      run_episode(1'b1, 1'b0, 32'h54, '0, 1'b0, '0, 0, 1);

      // Random traffic
      repeat (150) begin
         kind = $urandom_range(0, 2);
         run_episode(kind != 1, kind != 0, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                     $urandom, rand_dly(), rand_dly());
         idle_cycles($urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
